// File: rtl/bp_pkg.sv
// Shared constants, entry layout and sequencer states for the perceptron
// branch-predictor update path.
package bp_pkg;

   localparam int DEPTH     = 8;
   localparam int IDX_W     = 8;
   localparam int SUM_W     = 13;
   localparam int THETA     = 29;
   localparam int MAX_ALLOC = 4;
   localparam int PTR_W     = $clog2(DEPTH);
   localparam int CNT_W     = PTR_W + 1;

   localparam logic [2:0] GHR_ROLLBACK = 3'b111;

   typedef struct packed {
      logic [IDX_W-1:0]        row;
      logic                    pred;
      logic signed [SUM_W-1:0] sum;
   } bp_entry_t;

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } state_e;

   // One extra bit so the most negative sum has a representable magnitude.
   function automatic logic [SUM_W:0] abs_sum(input logic signed [SUM_W-1:0] s);
      logic signed [SUM_W:0] ext;
      ext = {s[SUM_W-1], s};
      return ext[SUM_W] ? (SUM_W+1)'(-ext) : ext;
   endfunction

endpackage

// File: rtl/bp_update_scheduler_if.sv
// Fetch/execute/table-side signal bundle for the branch-predictor update
// scheduler; master is the surrounding pipeline, slave is the scheduler.
interface bp_update_scheduler_if;
   import bp_pkg::*;

   // Allocation is a valid/ready handshake: a group of i_allocNum_3 > 0
   // branches is taken only when the scheduler can hold it (o_allocReady
   // guarantees MAX_ALLOC slots); a group presented otherwise is dropped.
   // Resolutions are valid-only and always refer to the oldest pending branch.
   logic [2:0]                 i_allocNum_3;
   logic [MAX_ALLOC*IDX_W-1:0] i_allocIdx_32;
   logic [MAX_ALLOC-1:0]       i_allocPred_4;
   logic [MAX_ALLOC*SUM_W-1:0] i_allocSum_52;
   logic                       o_allocReady;
   logic                       i_resValid;
   logic                       i_resTaken;
   logic [7:0]                 o_pendingB_8;
   logic [2:0]                 o_passBNum_3;
   logic                       o_updValid;
   logic [IDX_W-1:0]           o_updRow_8;
   logic                       o_updTaken;
   logic                       o_flush;
   logic                       o_stallFetch;
   logic                       o_ovf;
   state_e                     dbg_state;

   modport master (
      output i_allocNum_3, i_allocIdx_32, i_allocPred_4, i_allocSum_52,
      output i_resValid, i_resTaken,
      input  o_allocReady, o_pendingB_8, o_passBNum_3, o_updValid,
      input  o_updRow_8, o_updTaken, o_flush, o_stallFetch, o_ovf, dbg_state
   );

   modport slave (
      input  i_allocNum_3, i_allocIdx_32, i_allocPred_4, i_allocSum_52,
      input  i_resValid, i_resTaken,
      output o_allocReady, o_pendingB_8, o_passBNum_3, o_updValid,
      output o_updRow_8, o_updTaken, o_flush, o_stallFetch, o_ovf, dbg_state
   );

endinterface

// File: rtl/bp_train_decide.sv
// Perceptron training decision: retrain on a wrong direction or when the
// confidence |sum| is at or below the threshold.
module bp_train_decide
   import bp_pkg::*;
(
   input  logic                    pred_i,
   input  logic signed [SUM_W-1:0] sum_i,
   input  logic                    actual_i,
   output logic                    mispredict_o,
   output logic                    train_o
);

   logic [SUM_W:0] mag;

   assign mag          = abs_sum(sum_i);
   assign mispredict_o = pred_i ^ actual_i;
   assign train_o      = mispredict_o || (mag <= (SUM_W+1)'(THETA));

endmodule

// File: rtl/bp_update_scheduler.sv
// In-order branch tracking queue: records predictions, decides training on
// resolution, issues weight updates and sequences mispredict recovery.
module bp_update_scheduler
   import bp_pkg::*;
(
   input logic                  fire,
   input logic                  rst,
   bp_update_scheduler_if.slave bus
);

   bp_entry_t        mem_q [DEPTH];
   bp_entry_t        head_entry;
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d, free_slots;
   state_e           state_q, state_d;
   logic [2:0]       pass_q, pass_d, n_acc;
   logic             ready_q, ready_d, flush_q, flush_d, stall_q, stall_d;
   logic             ovf_q, ovf_d;
   logic             upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
   logic [IDX_W-1:0] upd_row_q, upd_row_d;
   logic             pop, mispredict, train, recover, alloc_acc;

   assign head_entry = mem_q[head_q];

   bp_train_decide u_decide (
      .pred_i       (head_entry.pred),
      .sum_i        (head_entry.sum),
      .actual_i     (bus.i_resTaken),
      .mispredict_o (mispredict),
      .train_o      (train)
   );

   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      state_d     = state_q;
      pass_d      = 3'd0;
      flush_d     = 1'b0;
      stall_d     = 1'b0;
      ovf_d       = 1'b0;
      upd_valid_d = 1'b0;
      upd_row_d   = upd_row_q;
      upd_taken_d = upd_taken_q;
      alloc_acc   = 1'b0;

      pop     = bus.i_resValid && (count_q != '0);
      recover = (state_q == RUN) && pop && mispredict;
      // The popped head slot counts as free for a same-cycle allocation.
      free_slots = CNT_W'(DEPTH) - count_q + CNT_W'(pop);

      if (bus.i_resValid && !pop) ovf_d = 1'b1;

      if (pop) begin
         head_d = head_q + PTR_W'(1);
         if (train) begin
            upd_valid_d = 1'b1;
            upd_row_d   = head_entry.row;
            upd_taken_d = bus.i_resTaken;
         end
      end

      case (state_q)
         RUN: begin
            if (recover) begin
               state_d = RECOVER;
            end else if (bus.i_allocNum_3 != 3'd0) begin
               if (bus.i_allocNum_3 <= 3'(MAX_ALLOC) &&
                   CNT_W'(bus.i_allocNum_3) <= free_slots)
                  alloc_acc = 1'b1;
               else
                  ovf_d = 1'b1;
            end
         end
         RECOVER: state_d = RUN;
         default: state_d = RUN;
      endcase

      n_acc = alloc_acc ? bus.i_allocNum_3 : 3'd0;

      // Recovery squashes every younger branch still in flight.
      if (recover) begin
         count_d = '0;
         tail_d  = head_q + PTR_W'(1);
         flush_d = 1'b1;
         stall_d = 1'b1;
         pass_d  = GHR_ROLLBACK;
      end else begin
         count_d = count_q - CNT_W'(pop) + CNT_W'(n_acc);
         tail_d  = tail_q + PTR_W'(n_acc);
         pass_d  = n_acc;
      end

      ready_d = (CNT_W'(DEPTH) - count_d) >= CNT_W'(MAX_ALLOC);
   end

   always_ff @(posedge fire or posedge rst) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         state_q     <= RUN;
         pass_q      <= 3'd0;
         ready_q     <= 1'b1;
         flush_q     <= 1'b0;
         stall_q     <= 1'b0;
         ovf_q       <= 1'b0;
         upd_valid_q <= 1'b0;
         upd_row_q   <= '0;
         upd_taken_q <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         state_q     <= state_d;
         pass_q      <= pass_d;
         ready_q     <= ready_d;
         flush_q     <= flush_d;
         stall_q     <= stall_d;
         ovf_q       <= ovf_d;
         upd_valid_q <= upd_valid_d;
         upd_row_q   <= upd_row_d;
         upd_taken_q <= upd_taken_d;
      end
   end

   // Storage needs no reset: count_q alone says which slots are live.
   always_ff @(posedge fire) begin
      if (alloc_acc) begin
         for (int i = 0; i < MAX_ALLOC; i++) begin
            if (i < int'(bus.i_allocNum_3)) begin
               mem_q[tail_q + PTR_W'(i)] <= '{
                  row:  bus.i_allocIdx_32[i*IDX_W +: IDX_W],
                  pred: bus.i_allocPred_4[i],
                  sum:  bus.i_allocSum_52[i*SUM_W +: SUM_W]
               };
            end
         end
      end
   end

   assign bus.o_allocReady = ready_q;
   assign bus.o_pendingB_8 = 8'(count_q);
   assign bus.o_passBNum_3 = pass_q;
   assign bus.o_updValid   = upd_valid_q;
   assign bus.o_updRow_8   = upd_row_q;
   assign bus.o_updTaken   = upd_taken_q;
   assign bus.o_flush      = flush_q;
   assign bus.o_stallFetch = stall_q;
   assign bus.o_ovf        = ovf_q;
   assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler and its training-decision block.
module tb_bp_update_scheduler;
   import bp_pkg::*;

   logic fire;
   logic rst;
   int   errors;
   int   checks;

   logic [IDX_W:0] exp_q[$];
   logic [IDX_W:0] exp_upd;

   bp_update_scheduler_if bus ();

   bp_update_scheduler dut (
      .fire (fire),
      .rst  (rst),
      .bus  (bus)
   );

   logic                    td_pred, td_act, td_mis, td_train;
   logic signed [SUM_W-1:0] td_sum;

   bp_train_decide u_td (
      .pred_i       (td_pred),
      .sum_i        (td_sum),
      .actual_i     (td_act),
      .mispredict_o (td_mis),
      .train_o      (td_train)
   );

   int   td_s     [7] = '{29, 30, -29, -30, -4096, 4095, 0};
   logic td_p     [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic td_a     [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic td_mis_e [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic td_trn_e [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   initial fire = 1'b0;
   always #5 fire = ~fire;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge fire);
      #1;
   endtask

   task automatic idle();
      bus.i_allocNum_3  = 3'd0;
      bus.i_allocIdx_32 = '0;
      bus.i_allocPred_4 = '0;
      bus.i_allocSum_52 = '0;
      bus.i_resValid    = 1'b0;
      bus.i_resTaken    = 1'b0;
   endtask

   task automatic alloc(input int n, input int r0, input int r1, input int r2, input int r3,
                        input logic [3:0] pred,
                        input int s0, input int s1, input int s2, input int s3);
      bus.i_allocNum_3  = 3'(n);
      bus.i_allocIdx_32 = {8'(r3), 8'(r2), 8'(r1), 8'(r0)};
      bus.i_allocPred_4 = pred;
      bus.i_allocSum_52 = {13'(s3), 13'(s2), 13'(s1), 13'(s0)};
   endtask

   task automatic res(input logic v, input logic t);
      bus.i_resValid = v;
      bus.i_resTaken = t;
   endtask

   // Update scoreboard: every weight update must match the oldest expected one.
   always @(negedge fire) begin
      if (bus.o_updValid !== 1'b0) begin
         checks++;
         assert (exp_q.size() != 0)
         else begin
            errors++;
            $error("FAIL upd_unexpected observed=row %0d expected=none", bus.o_updRow_8);
         end
         if (exp_q.size() != 0) begin
            exp_upd = exp_q.pop_front();
            checks++;
            assert ({bus.o_updRow_8, bus.o_updTaken} === exp_upd)
            else begin
               errors++;
               $error("FAIL upd_sb observed=%0h expected=%0h",
                      {bus.o_updRow_8, bus.o_updTaken}, exp_upd);
            end
         end
      end
   end

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      idle();
      td_pred = 1'b0;
      td_act  = 1'b0;
      td_sum  = '0;
      repeat (2) @(posedge fire);
      #1;

      for (int k = 0; k < 7; k++) begin
         td_pred = td_p[k];
         td_act  = td_a[k];
         td_sum  = 13'(td_s[k]);
         #1;
         chk("td_mis", 32'(td_mis), 32'(td_mis_e[k]));
         chk("td_train", 32'(td_train), 32'(td_trn_e[k]));
      end

      chk("rst_pend", bus.o_pendingB_8, 0);
      chk("rst_ready", bus.o_allocReady, 1);
      chk("rst_pass", bus.o_passBNum_3, 0);
      chk("rst_upd", bus.o_updValid, 0);
      chk("rst_flush", bus.o_flush, 0);
      chk("rst_stall", bus.o_stallFetch, 0);
      chk("rst_ovf", bus.o_ovf, 0);
      chk("rst_state", bus.dbg_state, RUN);
      rst = 1'b0;

      // Three-branch group, head resolves correctly with high confidence.
      alloc(3, 5, 6, 7, 0, 4'b0101, 40, -50, 35, 0);
      tick();
      chk("t1_pend", bus.o_pendingB_8, 3);
      chk("t1_pass", bus.o_passBNum_3, 3);
      chk("t1_ready", bus.o_allocReady, 1);
      idle();
      res(1'b1, 1'b1);
      tick();
      chk("t1_pend2", bus.o_pendingB_8, 2);
      chk("t1_pass2", bus.o_passBNum_3, 0);
      chk("t1_upd", bus.o_updValid, 0);

      // Low-confidence correct prediction trains.
      idle();
      alloc(1, 9, 0, 0, 0, 4'b0001, 10, 0, 0, 0);
      tick();
      chk("t2_pend", bus.o_pendingB_8, 3);
      chk("t2_pass", bus.o_passBNum_3, 1);
      idle();
      res(1'b1, 1'b0);
      tick();
      chk("t2_upd_r6", bus.o_updValid, 0);
      res(1'b1, 1'b1);
      tick();
      chk("t2_upd_r7", bus.o_updValid, 0);
      chk("t2_pend1", bus.o_pendingB_8, 1);
      exp_q.push_back({8'd9, 1'b1});
      tick();
      chk("t2_upd", bus.o_updValid, 1);
      chk("t2_row", bus.o_updRow_8, 9);
      chk("t2_taken", bus.o_updTaken, 1);
      chk("t2_flush", bus.o_flush, 0);
      chk("t2_pend0", bus.o_pendingB_8, 0);
      idle();
      tick();
      chk("t2_upd_off", bus.o_updValid, 0);

      // Mispredict with a concurrent allocation, then allocation in RECOVER.
      alloc(4, 1, 2, 3, 4, 4'b1111, 100, 100, 100, 100);
      tick();
      chk("t3_pend", bus.o_pendingB_8, 4);
      chk("t3_pass", bus.o_passBNum_3, 4);
      alloc(2, 50, 51, 0, 0, 4'b0011, 100, 100, 0, 0);
      res(1'b1, 1'b0);
      exp_q.push_back({8'd1, 1'b0});
      tick();
      chk("t3_flush", bus.o_flush, 1);
      chk("t3_stall", bus.o_stallFetch, 1);
      chk("t3_pass_rb", bus.o_passBNum_3, 7);
      chk("t3_pend0", bus.o_pendingB_8, 0);
      chk("t3_upd", bus.o_updValid, 1);
      chk("t3_row", bus.o_updRow_8, 1);
      chk("t3_taken", bus.o_updTaken, 0);
      chk("t3_ovf", bus.o_ovf, 0);
      chk("t3_state", bus.dbg_state, RECOVER);
      chk("t3_ready", bus.o_allocReady, 1);
      alloc(1, 52, 0, 0, 0, 4'b0001, 100, 0, 0, 0);
      res(1'b0, 1'b0);
      tick();
      chk("t3_flush_off", bus.o_flush, 0);
      chk("t3_stall_off", bus.o_stallFetch, 0);
      chk("t3_pass_rec", bus.o_passBNum_3, 0);
      chk("t3_pend_rec", bus.o_pendingB_8, 0);
      chk("t3_ovf_rec", bus.o_ovf, 0);
      chk("t3_state_run", bus.dbg_state, RUN);

      // Fill to capacity, overflow, then pop-enabled allocation when full.
      idle();
      alloc(4, 10, 11, 12, 13, 4'b0000, 200, 200, 200, 200);
      tick();
      chk("t4_pend4", bus.o_pendingB_8, 4);
      chk("t4_ready4", bus.o_allocReady, 1);
      alloc(4, 14, 15, 16, 17, 4'b0000, 200, 200, 200, 200);
      tick();
      chk("t4_pend8", bus.o_pendingB_8, 8);
      chk("t4_ready8", bus.o_allocReady, 0);
      chk("t4_pass8", bus.o_passBNum_3, 4);
      alloc(1, 20, 0, 0, 0, 4'b0000, 200, 0, 0, 0);
      tick();
      chk("t4_ovf", bus.o_ovf, 1);
      chk("t4_pend_ovf", bus.o_pendingB_8, 8);
      chk("t4_pass_ovf", bus.o_passBNum_3, 0);
      res(1'b1, 1'b0);
      tick();
      chk("t4_ovf_pop", bus.o_ovf, 0);
      chk("t4_pend_pop", bus.o_pendingB_8, 8);
      chk("t4_pass_pop", bus.o_passBNum_3, 1);
      chk("t4_ready_pop", bus.o_allocReady, 0);
      idle();
      tick();
      chk("t4_ovf_off", bus.o_ovf, 0);
      res(1'b1, 1'b0);
      for (int k = 0; k < 8; k++) tick();
      chk("t4_drained", bus.o_pendingB_8, 0);
      chk("t4_ready_drn", bus.o_allocReady, 1);

      // Resolve on empty queue, then magnitude boundaries.
      idle();
      res(1'b1, 1'b1);
      tick();
      chk("t5_ovf", bus.o_ovf, 1);
      chk("t5_upd", bus.o_updValid, 0);
      chk("t5_pend", bus.o_pendingB_8, 0);
      idle();
      tick();
      chk("t5_ovf_off", bus.o_ovf, 0);
      alloc(1, 30, 0, 0, 0, 4'b0001, -4096, 0, 0, 0);
      tick();
      chk("t5_pend1", bus.o_pendingB_8, 1);
      idle();
      res(1'b1, 1'b1);
      tick();
      chk("t5_min_upd", bus.o_updValid, 0);
      chk("t5_min_pend", bus.o_pendingB_8, 0);
      idle();
      alloc(2, 31, 32, 0, 0, 4'b0011, -29, 30, 0, 0);
      tick();
      chk("t5_pend2", bus.o_pendingB_8, 2);
      idle();
      res(1'b1, 1'b1);
      exp_q.push_back({8'd31, 1'b1});
      tick();
      chk("t5_theta_upd", bus.o_updValid, 1);
      chk("t5_theta_row", bus.o_updRow_8, 31);
      tick();
      chk("t5_over_upd", bus.o_updValid, 0);
      chk("t5_pend_end", bus.o_pendingB_8, 0);

      // Asynchronous reset with five trainable branches in flight.
      idle();
      alloc(4, 40, 41, 42, 43, 4'b1111, 5, 5, 5, 5);
      tick();
      alloc(1, 44, 0, 0, 0, 4'b0001, 5, 0, 0, 0);
      tick();
      chk("t6_pend5", bus.o_pendingB_8, 5);
      chk("t6_ready5", bus.o_allocReady, 0);
      idle();
      res(1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_pend_rst", bus.o_pendingB_8, 0);
      chk("t6_ready_rst", bus.o_allocReady, 1);
      chk("t6_pass_rst", bus.o_passBNum_3, 0);
      chk("t6_upd_rst", bus.o_updValid, 0);
      chk("t6_flush_rst", bus.o_flush, 0);
      chk("t6_stall_rst", bus.o_stallFetch, 0);
      chk("t6_ovf_rst", bus.o_ovf, 0);
      chk("t6_state_rst", bus.dbg_state, RUN);
      tick();
      chk("t6_upd_hold", bus.o_updValid, 0);
      idle();
      rst = 1'b0;
      tick();
      tick();
      chk("t6_pend_rel", bus.o_pendingB_8, 0);
      chk("t6_upd_rel", bus.o_updValid, 0);
      chk("t6_ovf_rel", bus.o_ovf, 0);

      chk("sb_empty", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
